// File: rtl/mc_ctrl_trap.sv
// Multicycle MIPS control FSM: ready-gated memory accesses with a bounded bus
// timeout, and traps for illegal opcode, overflow and bus timeout to an exception vector.
module mc_ctrl_trap #(
    parameter int MEM_TIMEOUT = 15,
    parameter bit TRAP_OVF    = 1'b1,
    parameter int ALU_OP_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         inst_in,
    input  logic                zero,
    input  logic                overflow,
    input  logic                mio_ready,
    output logic [4:0]          state_out,
    output logic                mem_read,
    output logic                mem_write,
    output logic                cpu_mio,
    output logic                iord,
    output logic                ir_write,
    output logic [1:0]          reg_dst,
    output logic                reg_write,
    output logic [1:0]          mem_to_reg,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch,
    output logic                pc_vec,
    output logic                epc_write,
    output logic                cause_write,
    output logic [1:0]          cause,
    output logic [ALU_OP_W-1:0] alu_op
);

    typedef enum logic [4:0] {
        S_IF      = 5'b00000,
        S_ID      = 5'b00001,
        S_EX_MEM  = 5'b00010,
        S_EX_R    = 5'b00011,
        S_EX_I    = 5'b00100,
        S_EX_LUI  = 5'b00101,
        S_EX_BEQ  = 5'b00110,
        S_EX_BNE  = 5'b00111,
        S_EX_J    = 5'b01000,
        S_EX_JAL  = 5'b01001,
        S_EX_JR   = 5'b01010,
        S_EX_JALR = 5'b01011,
        S_MEM_RD  = 5'b01100,
        S_MEM_WR  = 5'b01101,
        S_WB_LW   = 5'b01110,
        S_WB_R    = 5'b01111,
        S_WB_I    = 5'b10000,
        S_TRAP    = 5'b10001
    } state_t;

    localparam logic [1:0] C_ILL = 2'b00;
    localparam logic [1:0] C_OVF = 2'b01;
    localparam logic [1:0] C_BUS = 2'b10;

    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_cause;
    logic [1:0]       w_next_cause;
    logic [2:0]       w_alu_code;
    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic             w_mem_state;
    logic             w_timeout;
    logic             w_add_sub;
    logic             w_unused;

    assign w_op        = inst_in[31:26];
    assign w_funct     = inst_in[5:0];
    assign w_add_sub   = (w_funct == 6'h20) || (w_funct == 6'h22);
    assign w_mem_state = (r_state == S_IF) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout   = (MEM_TIMEOUT != 0) && !mio_ready && (r_cnt == CNT_LIMIT);
    assign state_out   = r_state;
    assign alu_op      = ALU_OP_W'(w_alu_code);
    assign w_unused    = &{1'b0, zero, inst_in[25:6]};

    function automatic logic [2:0] f_r_alu(input logic [5:0] funct);
        case (funct)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h26:   return 3'b011;
            6'h27:   return 3'b100;
            6'h2A:   return 3'b111;
            6'h02:   return 3'b101;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [2:0] f_i_alu(input logic [5:0] op);
        case (op)
            6'h0A:   return 3'b111;
            6'h0C:   return 3'b000;
            6'h0D:   return 3'b001;
            6'h0E:   return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IF;
            r_cnt   <= '0;
            r_cause <= C_ILL;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP)
                r_cause <= w_next_cause;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_mem_state && !mio_ready && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_next        = r_state;
        w_next_cause  = C_ILL;
        w_alu_code    = 3'b010;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        cpu_mio       = 1'b1;
        iord          = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 2'b00;
        reg_write     = 1'b0;
        mem_to_reg    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch        = 1'b0;
        pc_vec        = 1'b0;
        epc_write     = 1'b0;
        cause_write   = 1'b0;
        cause         = 2'b00;

        case (r_state)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // PC and IR only move on the cycle the fetch actually completes.
                if (mio_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_ID;
                end else if (w_timeout) begin
                    w_next       = S_TRAP;
                    w_next_cause = C_BUS;
                end
            end
            S_ID: begin
                alu_src_b = 2'b11;
                case (w_op)
                    6'h00: begin
                        case (w_funct)
                            6'h08:   w_next = S_EX_JR;
                            6'h09:   w_next = S_EX_JALR;
                            6'h20, 6'h22, 6'h24, 6'h25,
                            6'h26, 6'h27, 6'h2A, 6'h02:
                                     w_next = S_EX_R;
                            default: w_next = S_TRAP;
                        endcase
                    end
                    6'h23, 6'h2B:                      w_next = S_EX_MEM;
                    6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: w_next = S_EX_I;
                    6'h0F:   w_next = S_EX_LUI;
                    6'h04:   w_next = S_EX_BEQ;
                    6'h05:   w_next = S_EX_BNE;
                    6'h02:   w_next = S_EX_J;
                    6'h03:   w_next = S_EX_JAL;
                    default: w_next = S_TRAP;
                endcase
            end
            S_EX_MEM: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                w_next    = (w_op == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_EX_R: begin
                alu_src_a  = (w_funct == 6'h02) ? 2'b10 : 2'b01;
                w_alu_code = f_r_alu(w_funct);
                if (TRAP_OVF && overflow && w_add_sub) begin
                    w_next       = S_TRAP;
                    w_next_cause = C_OVF;
                end else begin
                    w_next = S_WB_R;
                end
            end
            S_EX_I: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_alu_code = f_i_alu(w_op);
                if (TRAP_OVF && overflow && (w_op == 6'h08)) begin
                    w_next       = S_TRAP;
                    w_next_cause = C_OVF;
                end else begin
                    w_next = S_WB_I;
                end
            end
            S_EX_LUI: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                w_next     = S_IF;
            end
            S_EX_BEQ, S_EX_BNE: begin
                alu_src_a     = 2'b01;
                w_alu_code    = 3'b110;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch        = (r_state == S_EX_BEQ);
                w_next        = S_IF;
            end
            S_EX_J, S_EX_JAL: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                if (r_state == S_EX_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b11;
                end
                w_next = S_IF;
            end
            S_EX_JR, S_EX_JALR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
                if (r_state == S_EX_JALR) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b01;
                    mem_to_reg = 2'b11;
                end
                w_next = S_IF;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mio_ready) begin
                    w_next = S_WB_LW;
                end else if (w_timeout) begin
                    w_next       = S_TRAP;
                    w_next_cause = C_BUS;
                end
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mio_ready) begin
                    w_next = S_IF;
                end else if (w_timeout) begin
                    w_next       = S_TRAP;
                    w_next_cause = C_BUS;
                end
            end
            S_WB_LW: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                w_next     = S_IF;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                w_next    = S_IF;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                w_next    = S_IF;
            end
            S_TRAP: begin
                epc_write   = 1'b1;
                cause_write = 1'b1;
                pc_write    = 1'b1;
                pc_vec      = 1'b1;
                cause       = r_cause;
                w_next      = S_IF;
            end
            default: w_next = S_TRAP;
        endcase
    end

endmodule
